// File: rtl/exe_unit_arbiter.sv
// exe_unit_arbiter: round-robin sharing of one multi-cycle execution unit
// among four requesters. Drives the operand mux select, runs the
// issue/ready handshake, waits for the completion strobe under a watchdog,
// and returns the registered result tagged with the owning requester.
module exe_unit_arbiter #(
  parameter int ARQ     = 16,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ack,
  output logic [1:0]     sel,
  output logic           issue_valid,
  input  logic           unit_ready,
  input  logic           unit_done,
  input  logic [ARQ-1:0] unit_result,
  output logic           resp_valid,
  output logic [1:0]     resp_id,
  output logic [ARQ-1:0] resp_data,
  output logic           busy,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Last WAIT cycle before the watchdog gives up on the unit.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    g;
  logic [TW-1:0] cnt;
  logic [1:0]    winner;
  logic          found;
  logic [1:0]    idx;
  logic          wd_expire;

  assign wd_expire = (cnt == CNT_LAST);

  // Round-robin search starting at ptr: the first active requester wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and handshake outputs; ack is combinational with unit_ready.
  always_comb begin
    state_nxt   = state;
    issue_valid = 1'b0;
    req_ack     = 4'b0000;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
        if (unit_ready) begin
          req_ack   = 4'b0001 << g;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (unit_done || wd_expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant, select, watchdog, pointer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= 2'd0;
      g           <= 2'd0;
      sel         <= 2'd0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 2'd0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            g   <= winner;
            sel <= winner;
          end
        end
        ISSUE: begin
          if (unit_ready) cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (unit_done) begin
            resp_data  <= unit_result;
            resp_id    <= g;
            resp_valid <= 1'b1;
            ptr        <= g + 2'd1;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            ptr         <= g + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Directed bench for exe_unit_arbiter with a short watchdog (TIMEOUT=4).
module tb_exe_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ack;
  logic [1:0]  sel;
  logic        issue_valid;
  logic        unit_ready;
  logic        unit_done;
  logic [15:0] unit_result;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  exe_unit_arbiter #(.ARQ(16), .TIMEOUT(4), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ack(req_ack),
    .sel(sel), .issue_valid(issue_valid), .unit_ready(unit_ready),
    .unit_done(unit_done), .unit_result(unit_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_id;
    rst_n       = 1'b0;
    req_valid   = 4'b0000;
    unit_ready  = 1'b0;
    unit_done   = 1'b0;
    unit_result = 16'h0000;

    // Reset state
    apply_reset();
    #1;
    check_output("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_output("rst_busy",        32'(busy),        32'd0);
    check_output("rst_sel",         32'(sel),         32'd0);
    check_output("rst_resp_valid",  32'(resp_valid),  32'd0);
    check_output("rst_timeout",     32'(timeout_err), 32'd0);
    check_output("rst_req_ack",     32'(req_ack),     32'd0);

    // Single request from requester 2
    req_valid  = 4'b0100;
    unit_ready = 1'b1;
    #1;
    check_output("single_idle_issue", 32'(issue_valid), 32'd0);
    step();
    check_output("single_issue_valid", 32'(issue_valid), 32'd1);
    check_output("single_sel",         32'(sel),         32'd2);
    check_output("single_ack",         32'(req_ack),     32'b0100);
    check_output("single_busy",        32'(busy),        32'd1);
    step();
    req_valid  = 4'b0000;
    unit_ready = 1'b0;
    #1;
    check_output("single_wait_ack",   32'(req_ack),     32'd0);
    check_output("single_wait_issue", 32'(issue_valid), 32'd0);
    check_output("single_wait_busy",  32'(busy),        32'd1);
    step();
    step();
    unit_done   = 1'b1;
    unit_result = 16'hBEEF;
    step();
    unit_done = 1'b0;
    #1;
    check_output("single_resp_valid", 32'(resp_valid), 32'd1);
    check_output("single_resp_id",    32'(resp_id),    32'd2);
    check_output("single_resp_data",  32'(resp_data),  32'hBEEF);
    check_output("single_idle_busy",  32'(busy),       32'd0);
    step();
    check_output("single_resp_pulse", 32'(resp_valid), 32'd0);

    // Fairness: all four requesting, unit always ready, done after one cycle
    apply_reset();
    req_valid  = 4'b1111;
    unit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_id = 2'(i);
      step();
      check_output($sformatf("fair_sel_%0d", i), 32'(sel), 32'(exp_id));
      check_output($sformatf("fair_ack_%0d", i), 32'(req_ack), 32'(4'b0001 << exp_id));
      step();
      unit_done   = 1'b1;
      unit_result = 16'(16'h1000 + i);
      step();
      unit_done = 1'b0;
      #1;
      check_output($sformatf("fair_resp_valid_%0d", i), 32'(resp_valid), 32'd1);
      check_output($sformatf("fair_resp_id_%0d", i), 32'(resp_id), 32'(exp_id));
      check_output($sformatf("fair_resp_data_%0d", i), 32'(resp_data), 32'(16'h1000 + i));
    end

    // Backpressure: requester 0, unit not ready for 5 cycles
    req_valid  = 4'b0001;
    unit_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("bp_issue_%0d", i), 32'(issue_valid), 32'd1);
      check_output($sformatf("bp_sel_%0d", i),   32'(sel),         32'd0);
      check_output($sformatf("bp_ack_%0d", i),   32'(req_ack),     32'd0);
      step();
    end
    unit_ready = 1'b1;
    #1;
    check_output("bp_ack_ready", 32'(req_ack), 32'b0001);
    step();
    req_valid  = 4'b0000;
    unit_ready = 1'b0;

    // Timeout: unit never completes, watchdog fires after 4 WAIT cycles
    step();
    step();
    step();
    check_output("to_busy_before",  32'(busy),        32'd1);
    check_output("to_err_before",   32'(timeout_err), 32'd0);
    step();
    check_output("to_err",          32'(timeout_err), 32'd1);
    check_output("to_busy",         32'(busy),        32'd0);
    check_output("to_no_resp",      32'(resp_valid),  32'd0);

    // Next request after timeout is still served; flag stays sticky
    req_valid  = 4'b0010;
    unit_ready = 1'b1;
    step();
    check_output("post_to_sel", 32'(sel),     32'd1);
    check_output("post_to_ack", 32'(req_ack), 32'b0010);
    step();
    req_valid   = 4'b0000;
    unit_ready  = 1'b0;
    unit_done   = 1'b1;
    unit_result = 16'h1234;
    step();
    unit_done = 1'b0;
    #1;
    check_output("post_to_resp_valid", 32'(resp_valid),  32'd1);
    check_output("post_to_resp_id",    32'(resp_id),     32'd1);
    check_output("post_to_resp_data",  32'(resp_data),   32'h1234);
    check_output("post_to_sticky",     32'(timeout_err), 32'd1);

    // Done coincides with last watchdog cycle: done wins
    apply_reset();
    check_output("rst2_timeout", 32'(timeout_err), 32'd0);
    req_valid  = 4'b1000;
    unit_ready = 1'b1;
    step();
    check_output("coin_sel", 32'(sel), 32'd3);
    step();
    req_valid  = 4'b0000;
    unit_ready = 1'b0;
    step();
    step();
    step();
    unit_done   = 1'b1;
    unit_result = 16'hCAFE;
    step();
    unit_done = 1'b0;
    #1;
    check_output("coin_resp_valid", 32'(resp_valid),  32'd1);
    check_output("coin_resp_id",    32'(resp_id),     32'd3);
    check_output("coin_resp_data",  32'(resp_data),   32'hCAFE);
    check_output("coin_timeout",    32'(timeout_err), 32'd0);
    step();
    check_output("coin_timeout_after", 32'(timeout_err), 32'd0);

    // Move the pointer away from 0 with a quick transaction from requester 0
    req_valid  = 4'b0001;
    unit_ready = 1'b1;
    step();
    step();
    req_valid = 4'b0000;
    unit_ready = 1'b0;
    unit_done = 1'b1;
    unit_result = 16'h0001;
    step();
    unit_done = 1'b0;

    // Reset mid-WAIT: transaction from requester 2 is dropped
    req_valid  = 4'b0100;
    unit_ready = 1'b1;
    step();
    step();
    req_valid  = 4'b0000;
    unit_ready = 1'b1;
    #1;
    check_output("mid_wait_busy", 32'(busy),    32'd1);
    check_output("stray_ready_ack", 32'(req_ack), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    unit_ready = 1'b0;
    #1;
    check_output("midrst_busy",  32'(busy),        32'd0);
    check_output("midrst_sel",   32'(sel),         32'd0);
    check_output("midrst_issue", 32'(issue_valid), 32'd0);
    check_output("midrst_resp",  32'(resp_valid),  32'd0);
    unit_done   = 1'b1;
    unit_result = 16'hDEAD;
    step();
    unit_done = 1'b0;
    #1;
    check_output("stray_done_resp", 32'(resp_valid), 32'd0);
    check_output("stray_done_busy", 32'(busy),       32'd0);

    // Pointer returned to 0: all requesting grants requester 0 first
    req_valid  = 4'b1111;
    unit_ready = 1'b1;
    step();
    check_output("midrst_ptr_sel", 32'(sel), 32'd0);
    check_output("midrst_ptr_ack", 32'(req_ack), 32'b0001);
    req_valid  = 4'b0000;
    unit_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
